// File: rtl/fifo_agilex7_sc_pkg.sv
// Shared types for the fifo_agilex7_sc single-clock FIFO: classification of
// the per-cycle access so occupancy bookkeeping reads as a case on the operation.
package fifo_agilex7_sc_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RDWR = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic wr_en, input logic rd_en);
        return fifo_op_e'({wr_en, rd_en});
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port DEPTH x WIDTH RAM with a registered read port; the
// ramstyle attribute steers the fitter towards MLAB or block RAM.
module fifo_sdp_ram #(
    parameter int DEPTH      = 512,
    parameter int WIDTH      = 32,
    parameter int AW         = $clog2(DEPTH),
    parameter int FORCE_MLAB = 0
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    generate
        if (FORCE_MLAB != 0) begin : g_mlab
            (* ramstyle = "MLAB, no_rw_check" *) logic [WIDTH-1:0] mem [DEPTH];
            logic [WIDTH-1:0] rd_data_q;

            always_ff @(posedge clock) begin
                if (wr_en) begin
                    mem[wr_addr] <= wr_data;
                end
                rd_data_q <= mem[rd_addr];
            end

            assign rd_data = rd_data_q;
        end else begin : g_m20k
            (* ramstyle = "M20K, no_rw_check" *) logic [WIDTH-1:0] mem [DEPTH];
            logic [WIDTH-1:0] rd_data_q;

            always_ff @(posedge clock) begin
                if (wr_en) begin
                    mem[wr_addr] <= wr_data;
                end
                rd_data_q <= mem[rd_addr];
            end

            assign rd_data = rd_data_q;
        end
    endgenerate

endmodule

// File: rtl/fifo_agilex7_sc.sv
// Single-clock FIFO with scfifo-style ports, showahead or normal read mode,
// overflow/underflow protection, synchronous and asynchronous clears.
module fifo_agilex7_sc
    import fifo_agilex7_sc_pkg::*;
#(
    parameter int    DEPTH      = 512,
    parameter int    WIDTH      = 32,
    parameter string SHOWAHEAD  = "ON",
    parameter int    FORCE_MLAB = 0
) (
    input  logic                       clock,
    input  logic                       aclr,
    input  logic                       sclr,
    input  logic [WIDTH-1:0]           data,
    input  logic                       wrreq,
    input  logic                       rdreq,
    output logic [WIDTH-1:0]           q,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] usedw
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    generate
        if (DEPTH < 2) begin : g_bad_depth
            $error("fifo_agilex7_sc: DEPTH must be at least 2");
        end
        if (SHOWAHEAD != "ON" && SHOWAHEAD != "OFF") begin : g_bad_mode
            $error("fifo_agilex7_sc: SHOWAHEAD must be \"ON\" or \"OFF\"");
        end
    endgenerate

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    usedw_q, usedw_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] byp_q, byp_d;
    logic             byp_sel_q, byp_sel_d;

    logic             wr_en;
    logic             rd_en;
    logic             ram_we;
    logic [WIDTH-1:0] ram_rd_data;
    logic [WIDTH-1:0] head;

    assign wr_en  = wrreq & ~full_q;
    assign rd_en  = rdreq & ~empty_q;
    assign ram_we = wr_en & ~sclr;

    // The RAM is addressed with the next read pointer so its registered output
    // already holds the new head after the edge that moves the pointer.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        usedw_d   = usedw_q;
        byp_d     = byp_q;
        byp_sel_d = byp_sel_q;

        case (fifo_op(wr_en, rd_en))
            OP_WR:   usedw_d = usedw_q + 1'b1;
            OP_RD:   usedw_d = usedw_q - 1'b1;
            default: usedw_d = usedw_q;
        endcase

        if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);

        // A word written into the slot that becomes the head is not yet visible
        // through the RAM read register, so it is captured here instead.
        if (wr_en || rd_en) begin
            byp_sel_d = wr_en && (wr_ptr_q == rd_ptr_d);
            if (wr_en && (wr_ptr_q == rd_ptr_d)) byp_d = data;
        end

        if (sclr) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            usedw_d   = '0;
            byp_d     = '0;
            byp_sel_d = 1'b1;
        end

        empty_d = (usedw_d == '0);
        full_d  = (usedw_d == CW'(DEPTH));
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            usedw_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            byp_q     <= '0;
            byp_sel_q <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            usedw_q   <= usedw_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            byp_q     <= byp_d;
            byp_sel_q <= byp_sel_d;
        end
    end

    fifo_sdp_ram #(
        .DEPTH      (DEPTH),
        .WIDTH      (WIDTH),
        .AW         (AW),
        .FORCE_MLAB (FORCE_MLAB)
    ) u_ram (
        .clock   (clock),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q),
        .wr_data (data),
        .rd_addr (rd_ptr_d),
        .rd_data (ram_rd_data)
    );

    assign head = byp_sel_q ? byp_q : ram_rd_data;

    generate
        if (SHOWAHEAD == "ON") begin : g_showahead
            assign q = head;
        end else begin : g_normal
            logic [WIDTH-1:0] q_q, q_d;

            always_comb begin
                q_d = q_q;
                if (rd_en) q_d = head;
                if (sclr)  q_d = '0;
            end

            always_ff @(posedge clock or posedge aclr) begin
                if (aclr) begin
                    q_q <= '0;
                end else begin
                    q_q <= q_d;
                end
            end

            assign q = q_q;
        end
    endgenerate

    assign empty = empty_q;
    assign full  = full_q;
    assign usedw = usedw_q;

endmodule

// File: tb/tb_fifo_agilex7_sc.sv
// Randomised scoreboard bench for fifo_agilex7_sc: a queue-based reference
// model predicts occupancy, flags and read data for three configurations.
module tb_fifo_agilex7_sc;

    logic clk;
    logic aclr;
    logic wr, rd, sc;
    logic [7:0] din;
    int   act;

    logic       wr0, rd0, sc0, wr1, rd1, sc1, wr2, rd2, sc2;
    logic [7:0] q0, q1, q2;
    logic       e0, e1, e2, f0, f1, f2;
    logic [2:0] u0, u1;
    logic [1:0] u2;

    logic [7:0] q_m;
    logic       empty_m, full_m;
    logic [2:0] usedw_m;

    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    int         cur_used;
    int         cur_dep;
    logic [7:0] cur_head;
    logic [7:0] cur_nq;
    logic [7:0] nq;
    bit         mon_en;
    bit         pend;
    int         hs_cnt;
    int         n_chk;
    int         n_fail;

    assign wr0 = wr & (act == 0);
    assign rd0 = rd & (act == 0);
    assign sc0 = sc & (act == 0);
    assign wr1 = wr & (act == 1);
    assign rd1 = rd & (act == 1);
    assign sc1 = sc & (act == 1);
    assign wr2 = wr & (act == 2);
    assign rd2 = rd & (act == 2);
    assign sc2 = sc & (act == 2);

    fifo_agilex7_sc #(.DEPTH(4), .WIDTH(8), .SHOWAHEAD("ON"), .FORCE_MLAB(0)) u_sa (
        .clock(clk), .aclr(aclr), .sclr(sc0), .data(din), .wrreq(wr0), .rdreq(rd0),
        .q(q0), .empty(e0), .full(f0), .usedw(u0)
    );

    fifo_agilex7_sc #(.DEPTH(4), .WIDTH(8), .SHOWAHEAD("OFF"), .FORCE_MLAB(1)) u_nm (
        .clock(clk), .aclr(aclr), .sclr(sc1), .data(din), .wrreq(wr1), .rdreq(rd1),
        .q(q1), .empty(e1), .full(f1), .usedw(u1)
    );

    fifo_agilex7_sc #(.DEPTH(3), .WIDTH(8), .SHOWAHEAD("ON"), .FORCE_MLAB(0)) u_wr (
        .clock(clk), .aclr(aclr), .sclr(sc2), .data(din), .wrreq(wr2), .rdreq(rd2),
        .q(q2), .empty(e2), .full(f2), .usedw(u2)
    );

    always_comb begin
        q_m = q0; empty_m = e0; full_m = f0; usedw_m = u0;
        case (act)
            1:       begin q_m = q1; empty_m = e1; full_m = f1; usedw_m = u1; end
            2:       begin q_m = q2; empty_m = e2; full_m = f2; usedw_m = {1'b0, u2}; end
            default: begin q_m = q0; empty_m = e0; full_m = f0; usedw_m = u0; end
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, a, e, $time);
        end
    endfunction

    // Monitor: compares flags every cycle and pops the scoreboard on each read handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("usedw", 32'(usedw_m), 32'(cur_used));
                chk("empty", 32'(empty_m), 32'(cur_used == 0));
                chk("full",  32'(full_m),  32'(cur_used == cur_dep));
                if (act != 1) begin
                    if (cur_used > 0) chk("q_head", 32'(q_m), 32'(cur_head));
                    if (rd && !empty_m) begin
                        hs_cnt++;
                        if (exp_q.size() == 0) begin
                            n_chk++; n_fail++;
                            $display("FAIL sb_read: got %0h, expected no read (t=%0t)", q_m, $time);
                        end else begin
                            chk("sb_read", 32'(q_m), 32'(exp_q.pop_front()));
                        end
                    end
                end else begin
                    chk("q_hold", 32'(q_m), 32'(cur_nq));
                    if (pend) begin
                        hs_cnt++;
                        if (exp_q.size() == 0) begin
                            n_chk++; n_fail++;
                            $display("FAIL sb_read: got %0h, expected no read (t=%0t)", q_m, $time);
                        end else begin
                            chk("sb_read", 32'(q_m), 32'(exp_q.pop_front()));
                        end
                    end
                    pend = rd && !empty_m;
                end
            end
        end
    end

    // One clock of stimulus; the model advances to the state after the coming edge.
    task automatic cyc(input bit w, input bit r, input logic [7:0] d, input bit c, output bit wok);
        bit         rok;
        logic [7:0] v;
        @(posedge clk);
        #1;
        wr = w; rd = r; din = d; sc = c;
        cur_used = mq.size();
        cur_nq   = nq;
        cur_head = 8'h00;
        if (mq.size() > 0) cur_head = mq[0];
        wok = 1'b0;
        if (c) begin
            mq.delete();
            nq = 8'h00;
        end else begin
            rok = r && (mq.size() > 0);
            wok = w && (mq.size() < cur_dep);
            if (rok) begin
                v = mq.pop_front();
                exp_q.push_back(v);
                nq = v;
            end
            if (wok) mq.push_back(d);
        end
    endtask

    task automatic do_aclr(input int k);
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; sc = 1'b0;
        act = k;
        cur_dep = (k == 2) ? 3 : 4;
        aclr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        aclr = 1'b0;
        @(negedge clk);
        chk("rst_q_sa",     32'(q0), 32'h0);
        chk("rst_q_nm",     32'(q1), 32'h0);
        chk("rst_q_wr",     32'(q2), 32'h0);
        chk("rst_empty_sa", 32'(e0), 32'h1);
        chk("rst_empty_nm", 32'(e1), 32'h1);
        chk("rst_empty_wr", 32'(e2), 32'h1);
        chk("rst_full_sa",  32'(f0), 32'h0);
        chk("rst_full_nm",  32'(f1), 32'h0);
        chk("rst_full_wr",  32'(f2), 32'h0);
        chk("rst_usedw_sa", 32'(u0), 32'h0);
        chk("rst_usedw_nm", 32'(u1), 32'h0);
        chk("rst_usedw_wr", 32'(u2), 32'h0);
        mq.delete();
        exp_q.delete();
        nq = 8'h00; cur_nq = 8'h00; cur_head = 8'h00; cur_used = 0;
        mon_en = 1'b1;
    endtask

    task automatic random_traffic(input int n);
        bit ok;
        for (int i = 0; i < n; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0, ok);
        end
        repeat (6) cyc(1'b0, 1'b1, 8'h00, 1'b0, ok);
        repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b0, ok);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        bit   ok;
        int   nxt;
        int   hs0;
        logic [7:0] fill [4];
        aclr = 1'b1; wr = 1'b0; rd = 1'b0; sc = 1'b0; din = 8'h00;
        act = 0; cur_dep = 4; mon_en = 1'b0; pend = 1'b0; hs_cnt = 0;
        n_chk = 0; n_fail = 0; cur_used = 0; nq = 8'h00; cur_nq = 8'h00; cur_head = 8'h00;
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

        // Showahead, DEPTH 4
        do_aclr(0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, fill[i], 1'b0, ok);
        cyc(1'b1, 1'b0, 8'h55, 1'b0, ok);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, ok);
        repeat (4) cyc(1'b0, 1'b1, 8'h00, 1'b0, ok);
        repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b0, ok);
        cyc(1'b1, 1'b0, 8'h61, 1'b0, ok);
        cyc(1'b1, 1'b0, 8'h62, 1'b0, ok);
        cyc(1'b1, 1'b1, 8'h63, 1'b0, ok);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, ok);
        cyc(1'b1, 1'b0, 8'h64, 1'b0, ok);
        cyc(1'b1, 1'b0, 8'h65, 1'b0, ok);
        cyc(1'b1, 1'b1, 8'h66, 1'b0, ok);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, ok);
        repeat (3) cyc(1'b0, 1'b1, 8'h00, 1'b0, ok);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, ok);
        cyc(1'b1, 1'b0, 8'h71, 1'b0, ok);
        cyc(1'b1, 1'b0, 8'h72, 1'b0, ok);
        cyc(1'b1, 1'b0, 8'h73, 1'b1, ok);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, ok);
        cyc(1'b1, 1'b0, 8'h77, 1'b0, ok);
        cyc(1'b0, 1'b1, 8'h00, 1'b0, ok);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, ok);
        cyc(1'b1, 1'b0, 8'h80, 1'b0, ok);
        for (int i = 1; i <= 20; i++) cyc(1'b1, 1'b1, 8'(8'h80 + i), 1'b0, ok);
        random_traffic(80);

        // Normal mode, DEPTH 4
        do_aclr(1);
        cyc(1'b1, 1'b0, 8'hA0, 1'b0, ok);
        cyc(1'b1, 1'b0, 8'hA1, 1'b0, ok);
        cyc(1'b0, 1'b1, 8'h00, 1'b0, ok);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, ok);
        cyc(1'b0, 1'b1, 8'h00, 1'b0, ok);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, ok);
        cyc(1'b0, 1'b1, 8'h00, 1'b0, ok);
        repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b0, ok);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(8'hB0 + i), 1'b0, ok);
        cyc(1'b1, 1'b1, 8'hBF, 1'b0, ok);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, ok);
        random_traffic(80);

        // Pointer wrap, DEPTH 3
        do_aclr(2);
        hs0 = hs_cnt;
        nxt = 1;
        for (int i = 0; i < 600 && (nxt <= 10 || mq.size() > 0); i++) begin
            cyc(1'((nxt <= 10) && ($urandom_range(0, 1) == 1)), 1'($urandom_range(0, 1)),
                8'(nxt), 1'b0, ok);
            if (ok) nxt++;
        end
        repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b0, ok);
        chk("wrap_read_count", 32'(hs_cnt - hs0), 32'd10);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
